binario_bcd_seq: RTL and testbench



---
 rtl/binario_bcd_seq.sv | 99 +++++++++
 tb/tb_binario_bcd_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/binario_bcd_seq.sv
// Sequential 14-bit binary to four-digit BCD converter (double-dabble, one bit per clock).
// Values above 9999 raise estouro and blank the digits with 4'b1111.
module binario_bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [13:0] binario,
  output logic [3:0]  milhar,
  output logic [3:0]  centena,
  output logic [3:0]  dezena,
  output logic [3:0]  unidade,
  output logic        ocupado,
  output logic        pronto,
  output logic        estouro
);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, FIM} estado_t;

  estado_t     estado_q;
  logic [13:0] desloc_q;
  logic [19:0] bcd_q;
  logic [3:0]  conta_q;
  logic [3:0]  milhar_q, centena_q, dezena_q, unidade_q;
  logic        pronto_q, estouro_q;

  logic [19:0] bcdAjust_d;
  logic [33:0] shift_d;

  // Add-3 correction on every nibble, then shift accumulator and operand as one register
  always_comb begin
    bcdAjust_d = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcdAjust_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shift_d = {bcdAjust_d, desloc_q} << 1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      desloc_q  <= '0;
      bcd_q     <= '0;
      conta_q   <= '0;
      milhar_q  <= '0;
      centena_q <= '0;
      dezena_q  <= '0;
      unidade_q <= '0;
      pronto_q  <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (inicio) begin
            desloc_q <= binario;
            bcd_q    <= '0;
            conta_q  <= '0;
            estado_q <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd_q    <= shift_d[33:14];
          desloc_q <= shift_d[13:0];
          conta_q  <= conta_q + 4'd1;
          if (conta_q == 4'd13)
            estado_q <= FIM;
        end
        FIM: begin
          // Nonzero ten-thousands nibble means the value does not fit in four digits
          estouro_q <= (bcd_q[19:16] != 4'd0);
          if (bcd_q[19:16] != 4'd0) begin
            milhar_q  <= 4'b1111;
            centena_q <= 4'b1111;
            dezena_q  <= 4'b1111;
            unidade_q <= 4'b1111;
          end else begin
            milhar_q  <= bcd_q[15:12];
            centena_q <= bcd_q[11:8];
            dezena_q  <= bcd_q[7:4];
            unidade_q <= bcd_q[3:0];
          end
          pronto_q <= 1'b1;
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign milhar  = milhar_q;
  assign centena = centena_q;
  assign dezena  = dezena_q;
  assign unidade = unidade_q;
  assign pronto  = pronto_q;
  assign estouro = estouro_q;
  assign ocupado = (estado_q != OCIOSO);

endmodule

// File: tb/tb_binario_bcd_seq.sv
// Scoreboard bench for binario_bcd_seq: the driver pushes decimal-arithmetic expectations,
// a negedge monitor pops them whenever pronto is seen.
module tb_binario_bcd_seq;

  localparam time PERIODO = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0;
  logic [13:0] binario = '0;
  logic [3:0]  milhar, centena, dezena, unidade;
  logic        ocupado, pronto, estouro;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] digitos;
    logic        est;
    time         tAceite;
    int          valor;
  } esperado_t;

  esperado_t sb[$];

  binario_bcd_seq dut (
    .clock   (clock),
    .reset   (reset),
    .inicio  (inicio),
    .binario (binario),
    .milhar  (milhar),
    .centena (centena),
    .dezena  (dezena),
    .unidade (unidade),
    .ocupado (ocupado),
    .pronto  (pronto),
    .estouro (estouro)
  );

  always #(PERIODO/2) clock = ~clock;

  function automatic esperado_t refModel(input int v, input time t);
    esperado_t e;
    e.valor   = v;
    e.tAceite = t;
    e.est     = (v > 9999);
    if (e.est)
      e.digitos = 16'hFFFF;
    else
      e.digitos = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return e;
  endfunction

  task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Presents value on inicio for one accepting edge; leaves the bench just after E0
  task automatic applyStimulus(input int valor, input bit rastrear);
    @(negedge clock);
    inicio  = 1'b1;
    binario = 14'(valor);
    @(posedge clock);
    if (rastrear) sb.push_back(refModel(valor, $time));
    @(negedge clock);
    inicio  = 1'b0;
    binario = 14'($urandom_range(0, 16383));
    checkOutput("ocupado_rise", {31'd0, ocupado}, 32'd1);
  endtask

  task automatic waitDone();
    repeat (15) @(posedge clock);
  endtask

  logic prontoAnt = 1'b0;

  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      if (prontoAnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL pronto_width: got 1 on consecutive cycles, expected single pulse at %0t", $time);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pronto: got pronto=1, expected no pending conversion at %0t", $time);
      end else begin
        esperado_t e;
        e = sb.pop_front();
        checkOutput($sformatf("digitos(%0d)", e.valor), {16'd0, milhar, centena, dezena, unidade}, {16'd0, e.digitos});
        checkOutput($sformatf("estouro(%0d)", e.valor), {31'd0, estouro}, {31'd0, e.est});
        checkOutput($sformatf("latencia(%0d)", e.valor), 32'($time - e.tAceite), 32'(15 * PERIODO + PERIODO / 2));
        checkOutput("ocupado_in_pronto", {31'd0, ocupado}, 32'd0);
      end
    end
    prontoAnt = (pronto === 1'b1);
  end

  initial begin
    int boundaries[4];
    time t0;
    boundaries = '{0, 9999, 10000, 16383};

    // Reset held two cycles with inicio asserted must not start anything
    reset   = 1'b1;
    inicio  = 1'b1;
    binario = 14'd1234;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_digitos", {16'd0, milhar, centena, dezena, unidade}, 32'd0);
    checkOutput("reset_pronto", {31'd0, pronto}, 32'd0);
    checkOutput("reset_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("reset_estouro", {31'd0, estouro}, 32'd0);
    reset  = 1'b0;
    inicio = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_ocupado", {31'd0, ocupado}, 32'd0);

    applyStimulus(1234, 1'b1);
    waitDone();

    foreach (boundaries[i]) begin
      applyStimulus(boundaries[i], 1'b1);
      waitDone();
    end

    // Ignored start while busy, then inicio held high for a back-to-back conversion
    @(negedge clock);
    inicio  = 1'b1;
    binario = 14'd5678;
    @(posedge clock);
    t0 = $time;
    sb.push_back(refModel(5678, t0));
    @(negedge clock);
    inicio = 1'b0;
    repeat (4) @(negedge clock);
    inicio  = 1'b1;
    binario = 14'd42;
    sb.push_back(refModel(42, t0 + 16 * PERIODO));
    repeat (12) @(posedge clock);
    @(negedge clock);
    inicio = 1'b0;
    waitDone();

    applyStimulus(4321, 1'b1);
    waitDone();

    // Abort 8765 with reset sampled on the seventh edge after acceptance
    applyStimulus(8765, 1'b0);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_digitos", {16'd0, milhar, centena, dezena, unidade}, 32'd0);
    checkOutput("abort_estouro", {31'd0, estouro}, 32'd0);
    checkOutput("abort_ocupado", {31'd0, ocupado}, 32'd0);
    repeat (20) @(negedge clock);
    applyStimulus(8765, 1'b1);
    waitDone();

    for (int n = 0; n < 20; n++) begin
      int v;
      v = (n % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      applyStimulus(v, 1'b1);
      waitDone();
    end

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
